video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter HW, default 11, horizontal counter and config width.
REQ-002 SHALL have parameter VW, default 10, vertical counter and config width.
REQ-003 SHALL have port clk_sys  in  1  system clock; the block is single-clock.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce_divider  in  4  pixel clock divider limit; 0 means 3, i.e. clk_sys/4.
REQ-006 SHALL have ports h_total, h_bstart, h_sstart, h_send  in  HW each  last pixel index, blank start, sync start, sync end (exclusive).
REQ-007 SHALL have ports v_total, v_bstart, v_sstart, v_send  in  VW each  last line index, blank start, sync start, sync end (exclusive).
REQ-008 SHALL have port pe  out  1  pixel enable, one clk_sys cycle wide.
REQ-009 SHALL have ports hcnt  out HW and vcnt  out VW  current pixel and line.
REQ-010 SHALL have ports hb, vb, hs, vs, de  out  1 each  blanks, active-high syncs, and display enable.
REQ-011 SHALL have ports line_start and frame_start  out  1 each  single-cycle pulses.

Function
REQ-012 SHALL run a divider div_cnt that increments every clk_sys cycle and reloads 0 after reaching div_lat; pe = (div_cnt == div_lat).
REQ-013 SHALL latch div_lat from adjusted ce_divider on every pe where hcnt wraps (line boundary), so the divider changes only between lines.
REQ-014 SHALL count hcnt and vcnt only on pe: hcnt==h_total -> hcnt=0 and vcnt+1; vcnt==v_total at that point -> vcnt=0.
REQ-015 SHALL register hb=(hcnt>=h_bstart), hs=(h_sstart<=hcnt<h_send), vb=(vcnt>=v_bstart), vs=(v_sstart<=vcnt<v_send), de=!hb&&!vb from the next counter values on the same edge, so they always match hcnt/vcnt.
REQ-016 SHALL pulse line_start on the pe cycle that loads hcnt=0, and frame_start when that load is also vcnt=0.
REQ-017 SHALL behave as follows at boundary settings: h_bstart>h_total never blanks; h_sstart>=h_send never syncs; h_total=0 gives one pixel per line; the same rules apply vertically.
REQ-018 SHALL wrap hcnt and vcnt modulo 2^HW and 2^VW with no error flag if the counters exceed the totals after a totals change.

Reset
REQ-019 SHALL clear div_cnt, hcnt, vcnt, hb, vb, hs, vs, de, line_start and frame_start on reset.
REQ-020 SHALL load div_lat and all shadow config from the inputs on reset.
REQ-021 SHALL assert the first pe on the div_lat-th cycle after reset deasserts, counting that first cycle as 0.
REQ-022 SHALL keep outputs 0 until that first pe.
REQ-023 SHALL return to the reset state on the next edge if reset asserts mid-line, with no partial pulse emitted.

Configuration
REQ-024 SHALL, with VTG_SHADOW_EN defined, decode all eight geometry inputs from shadow registers loaded only on frame_start edges, so mid-frame changes take effect from the next frame.
REQ-025 SHALL, without VTG_SHADOW_EN, decode the geometry inputs live every pe; div_lat latching per REQ-013 is unaffected.

Verification
REQ-026 SHALL cover: ce_divider=0 after reset -> pe period 4 cycles, first pe at cycle 3.
REQ-027 SHALL cover: h_total=9, h_bstart=8, h_sstart=8, h_send=9, ce_divider=1 -> hb high at hcnt 8,9; hs high only at hcnt 8; line_start every 20 clk_sys cycles.
REQ-028 SHALL cover: v_total=4, v_bstart=3, v_sstart=3, v_send=4 -> vs high for line 3 only; frame_start once every 5 lines with hcnt=vcnt=0.
REQ-029 SHALL cover: ce_divider changed 1->5 mid-line -> pe period stays 2 until the next line_start, then becomes 6.
REQ-030 SHALL cover: with VTG_SHADOW_EN, h_bstart changed 8->6 mid-frame -> unchanged until frame_start, then hb begins at hcnt 6; without the macro -> the change applies within the current line.
REQ-031 SHALL cover: reset pulsed at hcnt=5, vcnt=2 -> next cycle all outputs 0, then restart per REQ-021.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable divider, horizontal/vertical counters and
// registered blank/sync/DE flags. Define VTG_SHADOW_EN to latch geometry once per frame.
module video_timing_gen #(
  parameter int HW = 11,
  parameter int VW = 10
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [3:0]    ce_divider,
  input  logic [HW-1:0] h_total,
  input  logic [HW-1:0] h_bstart,
  input  logic [HW-1:0] h_sstart,
  input  logic [HW-1:0] h_send,
  input  logic [VW-1:0] v_total,
  input  logic [VW-1:0] v_bstart,
  input  logic [VW-1:0] v_sstart,
  input  logic [VW-1:0] v_send,
  output logic          pe,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hb,
  output logic          vb,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  typedef struct packed {
    logic [HW-1:0] total;
    logic [HW-1:0] bstart;
    logic [HW-1:0] sstart;
    logic [HW-1:0] send;
  } h_geom_t;

  typedef struct packed {
    logic [VW-1:0] total;
    logic [VW-1:0] bstart;
    logic [VW-1:0] sstart;
    logic [VW-1:0] send;
  } v_geom_t;

  logic [3:0]    div_adj;
  logic [3:0]    div_cnt_q, div_cnt_d;
  logic [3:0]    div_lat_q, div_lat_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hb_q, hb_d, hs_q, hs_d, vb_q, vb_d, vs_q, vs_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic          pe_w, h_wrap, frame_wrap;
  h_geom_t       h_in, h_cur, h_dec;
  v_geom_t       v_in, v_cur, v_dec;

  // A zero divider setting selects the default clk_sys/4 pixel rate.
  assign div_adj = (ce_divider == 4'd0) ? 4'd3 : ce_divider;
  assign h_in    = {h_total, h_bstart, h_sstart, h_send};
  assign v_in    = {v_total, v_bstart, v_sstart, v_send};

`ifdef VTG_SHADOW_EN
  h_geom_t h_sh_q, h_sh_d;
  v_geom_t v_sh_q, v_sh_d;

  // The frame-boundary edge already decodes pixel (0,0) with the new geometry.
  assign h_sh_d = frame_wrap ? h_in : h_sh_q;
  assign v_sh_d = frame_wrap ? v_in : v_sh_q;
  assign h_cur  = h_sh_q;
  assign v_cur  = v_sh_q;
  assign h_dec  = h_sh_d;
  assign v_dec  = v_sh_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_sh_q <= h_in;
      v_sh_q <= v_in;
    end else begin
      h_sh_q <= h_sh_d;
      v_sh_q <= v_sh_d;
    end
  end
`else
  assign h_cur = h_in;
  assign v_cur = v_in;
  assign h_dec = h_in;
  assign v_dec = v_in;
`endif

  always_comb begin
    pe_w      = (div_cnt_q == div_lat_q);
    h_wrap    = pe_w && (hcnt_q == h_cur.total);
    div_cnt_d = pe_w ? 4'd0 : div_cnt_q + 4'd1;
    div_lat_d = h_wrap ? div_adj : div_lat_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == v_cur.total) ? '0 : vcnt_q + VW'(1);
    end else if (pe_w) begin
      hcnt_d = hcnt_q + HW'(1);
    end
    frame_wrap = h_wrap && (vcnt_d == '0);
  end

  // Flags are decoded from the next counter values so they line up with hcnt/vcnt.
  always_comb begin
    hb_d = hb_q;
    hs_d = hs_q;
    vb_d = vb_q;
    vs_d = vs_q;
    de_d = de_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (pe_w) begin
      hb_d = (hcnt_d >= h_dec.bstart);
      hs_d = (hcnt_d >= h_dec.sstart) && (hcnt_d < h_dec.send);
      vb_d = (vcnt_d >= v_dec.bstart);
      vs_d = (vcnt_d >= v_dec.sstart) && (vcnt_d < v_dec.send);
      de_d = !hb_d && !vb_d;
      ls_d = h_wrap;
      fs_d = frame_wrap;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt_q <= 4'd0;
      div_lat_q <= div_adj;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hb_q      <= 1'b0;
      hs_q      <= 1'b0;
      vb_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hb_q      <= hb_d;
      hs_q      <= hs_d;
      vb_q      <= vb_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
    end
  end

  assign pe          = pe_w;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hb          = hb_q;
  assign hs          = hs_q;
  assign vb          = vb_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
